entrada_operandos: RTL
======================

Name: entrada_operandos

Overview:
- Operand-entry sequencer directly upstream of the calculator ALU.
- Reads four switches and two push-buttons, and drives the ALU inputs `num1`, `num2` and `operacao`.
- The user enters first operand, second operand, then operation, each confirmed with a button press; the result is then shown until the next confirm.
- Contains a 2-flop synchronizer, a debouncer and rising-edge detection for the confirm button, plus a 4-state FSM.

Parameters:
- DEBOUNCE_CICLOS, 50000, consecutive cycles the synchronized button must differ from its stable value before the stable value flips; legal range >=1; bench uses 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- chaves  in  4  raw switch value; sampled directly, treated as static when confirm fires
- botao_confirma  in  1  raw, asynchronous, bouncing confirm button, active-high
- botao_limpa  in  1  raw, asynchronous clear button, active-high
- num1  out  4  registered first operand to ALU
- num2  out  4  registered second operand to ALU
- operacao  out  2  registered operation to ALU: 00 none/zero, 01 add, 10 sub, 11 mult
- resultado_valido  out  1  high while the ALU output is to be displayed
- estado  out  2  current FSM state for status LEDs

Behaviour:
- Clocking and reset
  - All state updates on rising clk.
  - rst has top priority.
  - On rst: num1=0, num2=0, operacao=00, resultado_valido=0, estado=LE_NUM1.
  - On rst: sync flops=0, debounce stable value=0, debounce counter=0.
- Synchronizers
  - botao_confirma passes through 2 flops (sync1, sync2).
  - botao_limpa passes through its own 2 flops; it is not debounced.
- Debouncer
  - If sync2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CICLOS-1: stable <= sync2, counter <= 0.
  - Else: counter++.
  - Counter width = clog2(DEBOUNCE_CICLOS)+1.
- Confirm pulse
  - pulso = stable & ~stable_q, where stable_q is stable delayed 1 cycle; combinational, exactly 1 cycle wide per press.
  - Release of the button produces no pulse.
- Latency
  - Raw button first sampled high at edge 1 and held.
  - stable rises at edge DEBOUNCE_CICLOS+2.
  - pulso is high in the cycle after that edge.
  - FSM/register update is visible after edge DEBOUNCE_CICLOS+3.
- FSM states, encoded onto estado:
  - LE_NUM1=00: on pulso, num1 <= chaves, go LE_NUM2.
  - LE_NUM2=01: on pulso, num2 <= chaves, go LE_OP.
  - LE_OP=10: on pulso, operacao <= chaves[1:0], go EXIBE.
  - EXIBE=11: resultado_valido=1 (Moore, registered with state); on pulso, clear num1/num2/operacao to 0, go LE_NUM1.
- Outputs outside EXIBE
  - resultado_valido=0 in all states other than EXIBE.
  - operacao stays 00 outside EXIBE, so the ALU shows 0 during entry.
- Clear: synchronized botao_limpa=1 (sync2) in any state
  - Same effect as reset on num1, num2, operacao, resultado_valido, estado.
  - Debouncer is not touched.
  - Takes priority over a simultaneous pulso.
  - Held clear keeps FSM in LE_NUM1; pulses during clear are discarded.
- Held confirm: advances exactly one state; a second advance requires release (stable back to 0) and a new press.
- Bounce: any glitch shorter than DEBOUNCE_CICLOS cycles resets the counter and produces no pulse.
- Switch changes without pulso: no effect on outputs.
- rst mid-debounce: counter and stable cleared; a press held across rst release is re-debounced from zero and generates one pulse.

Test Plan:
- Reset: assert rst 2 cycles with buttons high -> all outputs 0, estado=00; after release with confirm held, one pulse after DEBOUNCE_CICLOS+3 cycles; estado=01.
- Full add sequence (DEBOUNCE_CICLOS=4): chaves=0101 press, 0011 press, 0001 press -> num1=5, num2=3, operacao=01, estado=11, resultado_valido=1 (ALU 8).
- Mult: enter 15, 15, op 11 -> operacao=11, resultado_valido=1 (ALU 225); next press -> all cleared, estado=00.
- Bounce: confirm toggles high 3 cycles, low 1, high 2, low -> no state change; then held 10 cycles -> exactly one advance, 7 cycles after hold start.
- Clear priority: in LE_OP with num1=9, num2=2, assert limpa in same cycle as pulso -> estado=00, num1=num2=0, operacao=00.
- Held confirm 100 cycles in LE_NUM1 -> estado=01 only; changing chaves while held -> num1 unchanged.

Source files
------------

// File: rtl/entrada_operandos.sv
// entrada_operandos: operand-entry sequencer feeding the calculator ALU
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   chaves[3:0]       - raw switches, captured on each confirm
//   botao_confirma    - raw bouncing confirm button (synchronized + debounced)
//   botao_limpa       - raw clear button (synchronized only)
//   num1, num2        - registered operands to ALU
//   operacao          - registered ALU operation (00 none, 01 add, 10 sub, 11 mult)
//   resultado_valido  - high while the ALU result is displayed
//   estado            - current FSM state for status LEDs
module entrada_operandos #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] chaves,
    input  logic       botao_confirma,
    input  logic       botao_limpa,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [1:0] operacao,
    output logic       resultado_valido,
    output logic [1:0] estado
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    typedef enum logic [1:0] {LE_NUM1 = 2'b00, LE_NUM2 = 2'b01, LE_OP = 2'b10, EXIBE = 2'b11} estado_t;
    estado_t st;
    logic conf_s1, conf_s2, limpa_s1, limpa_s2, estavel, estavel_q;
    logic [CW-1:0] cont;
    logic pulso;
    // one-cycle pulse on the debounced rising edge only
    assign pulso = estavel & ~estavel_q;
    assign estado = st;
    always_ff @(posedge clk) begin
        if (rst) begin
            conf_s1   <= 1'b0;
            conf_s2   <= 1'b0;
            limpa_s1  <= 1'b0;
            limpa_s2  <= 1'b0;
            estavel   <= 1'b0;
            estavel_q <= 1'b0;
            cont      <= '0;
        end else begin
            conf_s1   <= botao_confirma;
            conf_s2   <= conf_s1;
            limpa_s1  <= botao_limpa;
            limpa_s2  <= limpa_s1;
            estavel_q <= estavel;
            // stable value flips only after DEBOUNCE_CICLOS consecutive differing samples
            if (conf_s2 == estavel)
                cont <= '0;
            else if (cont == CW'(DEBOUNCE_CICLOS - 1)) begin
                estavel <= conf_s2;
                cont    <= '0;
            end else
                cont <= cont + CW'(1);
        end
    end
    // clear has priority over a simultaneous confirm pulse
    always_ff @(posedge clk) begin
        if (rst || limpa_s2) begin
            st               <= LE_NUM1;
            num1             <= '0;
            num2             <= '0;
            operacao         <= '0;
            resultado_valido <= 1'b0;
        end else if (pulso) begin
            unique case (st)
                LE_NUM1: begin
                    num1 <= chaves;
                    st   <= LE_NUM2;
                end
                LE_NUM2: begin
                    num2 <= chaves;
                    st   <= LE_OP;
                end
                LE_OP: begin
                    operacao         <= chaves[1:0];
                    resultado_valido <= 1'b1;
                    st               <= EXIBE;
                end
                EXIBE: begin
                    num1             <= '0;
                    num2             <= '0;
                    operacao         <= '0;
                    resultado_valido <= 1'b0;
                    st               <= LE_NUM1;
                end
            endcase
        end
    end
endmodule
